// File: rtl/imem_prog.sv
// Run-time loadable instruction memory: byte-wide load port packs into W-bit words,
// 1-cycle registered fetch. Define IMEM_BIG_ENDIAN_EN for MSB-first byte packing.
module imem_prog #(
  parameter int W  = 32,
  parameter int D  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ld_start,
  input  logic          i_ld_valid,
  input  logic [7:0]    i_ld_data,
  input  logic          i_ld_last,
  output logic          o_ld_ready,
  input  logic          i_fetch_req,
  input  logic [AW-1:0] i_fetch_addr,
  output logic          o_rd_valid,
  output logic [W-1:0]  o_rd_data,
  output logic          o_rd_err,
  output logic          o_busy,
  output logic [AW:0]   o_words_loaded
);

  localparam int NB = W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(D - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(D);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_waddr, w_waddr_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic [W-1:0]  r_shift, w_shift_nxt;
  logic [AW:0]   r_words, w_words_nxt;
  logic          r_rd_valid, r_rd_err;
  logic [W-1:0]  r_rd_data;

  logic          w_we;
  logic [W-1:0]  w_wdata;
  logic [W-1:0]  w_word;
  logic          w_xfer;
  logic          w_addr_ok;

  logic [W-1:0]  r_mem [D];

  assign o_ld_ready     = (r_state == ST_LOAD);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_words_loaded = r_words;
  assign o_rd_valid     = r_rd_valid;
  assign o_rd_data      = r_rd_data;
  assign o_rd_err       = r_rd_err;

  assign w_xfer    = i_ld_valid && o_ld_ready;
  assign w_addr_ok = ({1'b0, i_fetch_addr} < DEPTH);

  // Drop the incoming byte into its lane; lanes not yet received stay zero,
  // which is also the padding for a word closed early by ld_last.
  always_comb begin
    w_word = r_shift;
    for (int k = 0; k < NB; k++) begin
      if (r_bcnt == BW'(k)) begin
`ifdef IMEM_BIG_ENDIAN_EN
        w_word[W-8-8*k +: 8] = i_ld_data;
`else
        w_word[8*k +: 8] = i_ld_data;
`endif
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_waddr_nxt = r_waddr;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_words_nxt = r_words;
    w_we        = 1'b0;
    w_wdata     = '0;

    unique case (r_state)
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_waddr == LAST_ADDR) begin
          w_waddr_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_waddr_nxt = r_waddr + 1'b1;
        end
      end

      ST_IDLE: begin
        if (i_ld_start) begin
          w_state_nxt = ST_LOAD;
          w_waddr_nxt = '0;
          w_bcnt_nxt  = '0;
          w_shift_nxt = '0;
          w_words_nxt = '0;
        end
      end

      ST_LOAD: begin
        if (i_ld_start) begin
          // Restart discards the partial word; words already stored are kept.
          w_waddr_nxt = '0;
          w_bcnt_nxt  = '0;
          w_shift_nxt = '0;
          w_words_nxt = '0;
        end else if (w_xfer) begin
          if (i_ld_last || (r_bcnt == LAST_BYTE)) begin
            w_we        = 1'b1;
            w_wdata     = w_word;
            w_waddr_nxt = r_waddr + 1'b1;
            w_words_nxt = r_words + 1'b1;
            w_bcnt_nxt  = '0;
            w_shift_nxt = '0;
            if (i_ld_last || (r_waddr == LAST_ADDR)) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_shift_nxt = w_word;
            w_bcnt_nxt  = r_bcnt + 1'b1;
          end
        end
      end

      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_CLEAR;
      r_waddr <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_waddr <= w_waddr_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
      r_words <= w_words_nxt;
    end
  end

  // NOTE: the array has no reset clause; the CLEAR sequence defines its contents.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_waddr] <= w_wdata;
    end
  end

  // Fetches are only served in IDLE, so a read never meets a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else if (i_fetch_req) begin
      r_rd_valid <= 1'b1;
      if ((r_state == ST_IDLE) && w_addr_ok) begin
        r_rd_err  <= 1'b0;
        r_rd_data <= r_mem[i_fetch_addr];
      end else begin
        r_rd_err  <= 1'b1;
        r_rd_data <= '0;
      end
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: a D=32 and a D=20 instance share all inputs; fetch results
// are checked through a scoreboard queue and small vector tables.
module tb_imem_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ld_start, i_ld_valid, i_ld_last;
  logic [7:0]  i_ld_data;
  logic        i_fetch_req;
  logic [4:0]  i_fetch_addr;

  logic        o_ld_ready, o_rd_valid, o_rd_err, o_busy;
  logic [31:0] o_rd_data;
  logic [5:0]  o_words_loaded;

  logic        o20_ld_ready, o20_rd_valid, o20_rd_err, o20_busy;
  logic [31:0] o20_rd_data;
  logic [5:0]  o20_words_loaded;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          sel20;
    logic        err;
    logic [31:0] data;
    string       name;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic        err;
    logic [31:0] data;
  } fvec_t;

  exp_t  sb[$];
  fvec_t tbl[$];

  imem_prog #(.W(32), .D(32), .AW(5)) u_dut (
    .clk(clk), .rst(rst),
    .i_ld_start(i_ld_start), .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .i_ld_last(i_ld_last), .o_ld_ready(o_ld_ready),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_err(o_rd_err),
    .o_busy(o_busy), .o_words_loaded(o_words_loaded)
  );

  imem_prog #(.W(32), .D(20), .AW(5)) u_dut20 (
    .clk(clk), .rst(rst),
    .i_ld_start(i_ld_start), .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .i_ld_last(i_ld_last), .o_ld_ready(o20_ld_ready),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_rd_valid(o20_rd_valid), .o_rd_data(o20_rd_data), .o_rd_err(o20_rd_err),
    .o_busy(o20_busy), .o_words_loaded(o20_words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input logic [7:0] b0, b1, b2, b3);
`ifdef IMEM_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  o_busy, 1);
    check({tag, "_ready"}, o_ld_ready, 0);
    check({tag, "_valid"}, o_rd_valid, 0);
    check({tag, "_data"},  o_rd_data, 0);
    check({tag, "_err"},   o_rd_err, 0);
    check({tag, "_words"}, o_words_loaded, 0);
  endtask

  // Called at a negedge right after rst is released; counts CLEAR cycles.
  task automatic count_busy(input string name);
    int cnt = 0;
    while (o_busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check(name, cnt, 32);
  endtask

  task automatic sb_pop_compare();
    exp_t e;
    e = sb.pop_front();
    if (e.sel20) begin
      check({e.name, "_valid"}, o20_rd_valid, 1);
      check({e.name, "_err"},   o20_rd_err, e.err);
      check({e.name, "_data"},  o20_rd_data, e.data);
    end else begin
      check({e.name, "_valid"}, o_rd_valid, 1);
      check({e.name, "_err"},   o_rd_err, e.err);
      check({e.name, "_data"},  o_rd_data, e.data);
    end
  endtask

  task automatic fetch(input logic [4:0] addr, input bit sel20, input logic err,
                       input logic [31:0] data, input string name);
    exp_t e;
    i_fetch_req  = 1'b1;
    i_fetch_addr = addr;
    e.sel20 = sel20; e.err = err; e.data = data; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    i_fetch_req = 1'b0;
    sb_pop_compare();
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) fetch(tbl[i].addr, 1'b0, tbl[i].err, tbl[i].data, $sformatf("%s%0d", name, i));
    tbl.delete();
  endtask

  task automatic load_start();
    i_ld_start = 1'b1;
    @(negedge clk);
    i_ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input bit gap);
    int t = 0;
    while (!o_ld_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      check("ld_ready_wait", o_ld_ready, 1);
      return;
    end
    i_ld_valid = 1'b1;
    i_ld_data  = b;
    i_ld_last  = last;
    @(negedge clk);
    i_ld_valid = 1'b0;
    i_ld_last  = 1'b0;
    if (gap) @(negedge clk);
  endtask

  initial begin
    logic [7:0] s1 [4];
    rst = 1'b0;
    i_ld_start = 0; i_ld_valid = 0; i_ld_last = 0; i_ld_data = 0;
    i_fetch_req = 0; i_fetch_addr = 0;

    // Reset state, then CLEAR length
    repeat (3) @(negedge clk);
    check_reset_values("rst0");
    rst = 1'b1;
    count_busy("clear_len");
    fetch(5'd5, 1'b0, 1'b0, 32'h0, "idle_a5");

    // Single word with ld_valid toggling, ld_last on byte 3
    s1[0] = 8'h03; s1[1] = 8'h00; s1[2] = 8'h41; s1[3] = 8'h54;
    load_start();
    for (int i = 0; i < 4; i++) send_byte(s1[i], i == 3, 1'b1);
    check("w1_words", o_words_loaded, 1);
    check("w1_busy", o_busy, 0);
    fetch(5'd0, 1'b0, 1'b0, pk(s1[0], s1[1], s1[2], s1[3]), "w1_a0");
    @(negedge clk);
    check("nofetch_valid", o_rd_valid, 0);
    check("nofetch_hold", o_rd_data, pk(s1[0], s1[1], s1[2], s1[3]));

    // Ten bytes: two full words plus a zero-padded partial word
    load_start();
    for (int i = 1; i <= 10; i++) send_byte(8'(i), i == 10, 1'b0);
    check("w10_words", o_words_loaded, 3);
    tbl.push_back('{5'd0, 1'b0, pk(8'h01, 8'h02, 8'h03, 8'h04)});
    tbl.push_back('{5'd1, 1'b0, pk(8'h05, 8'h06, 8'h07, 8'h08)});
    tbl.push_back('{5'd2, 1'b0, pk(8'h09, 8'h0A, 8'h00, 8'h00)});
    tbl.push_back('{5'd3, 1'b0, 32'h0});
    run_table("w10_");

    // Fetch rejected while loading, accepted afterwards
    load_start();
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 0, 0);
    send_byte(8'hCC, 0, 0); send_byte(8'hDD, 0, 0);
    check("ld_busy", o_busy, 1);
    fetch(5'd1, 1'b0, 1'b1, 32'h0, "busy_a1");
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
    send_byte(8'h33, 0, 0); send_byte(8'h44, 1, 0);
    check("busy_words", o_words_loaded, 2);
    fetch(5'd1, 1'b0, 1'b0, pk(8'h11, 8'h22, 8'h33, 8'h44), "done_a1");

    // Range check on both depths
    fetch(5'd25, 1'b1, 1'b1, 32'h0, "d20_a25");
    fetch(5'd19, 1'b1, 1'b0, 32'h0, "d20_a19");
    fetch(5'd25, 1'b0, 1'b0, 32'h0, "d32_a25");

    // Fill to the last word; further bytes refused
    load_start();
    for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0, 1'b0);
    check("full_ready", o_ld_ready, 0);
    check("full_busy", o_busy, 0);
    check("full_words", o_words_loaded, 32);
    check("full20_words", o20_words_loaded, 20);
    i_ld_valid = 1'b1; i_ld_data = 8'hFF;
    repeat (2) @(negedge clk);
    i_ld_valid = 1'b0;
    check("full_extra_words", o_words_loaded, 32);
    fetch(5'd31, 1'b0, 1'b0, pk(8'h7C, 8'h7D, 8'h7E, 8'h7F), "full_a31");

    // Restart mid-word: partial bytes dropped, older words kept
    load_start();
    send_byte(8'hEE, 0, 0); send_byte(8'hFF, 0, 0);
    load_start();
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h03, 0, 0); send_byte(8'h04, 1, 0);
    check("rs_words", o_words_loaded, 1);
    tbl.push_back('{5'd0, 1'b0, pk(8'h01, 8'h02, 8'h03, 8'h04)});
    tbl.push_back('{5'd1, 1'b0, pk(8'h04, 8'h05, 8'h06, 8'h07)});
    run_table("rs_");

    // Reset in the middle of a load
    load_start();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0);
    check("mid_words", o_words_loaded, 2);
    rst = 1'b0;
    #1;
    check_reset_values("rst1");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    count_busy("clear_len2");
    fetch(5'd0, 1'b0, 1'b0, 32'h0, "rst_a0");
    fetch(5'd1, 1'b0, 1'b0, 32'h0, "rst_a1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
